// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames into command words and
// serialises read data returned by the memory stage onto MISO.
// Ports: CLK, RST (async, active-low), SS_n, MOSI, MISO,
//        rx_data/rx_valid (to memory stage), tx_data/tx_valid (from it).
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int W = ADDR_SIZE + 2;
  localparam logic [3:0] NBITS = 4'(W);
  localparam logic [3:0] TXLAST = 4'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t state, state_nx;

  logic [3:0]           cnt;
  logic [W-1:0]         shreg;
  logic                 frame_done;
  logic                 rd_addr_done;
  logic                 tx_sent;
  logic [3:0]           tx_cnt;
  logic [ADDR_SIZE-1:0] tx_sh;
  logic                 tx_cap;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (!SS_n) state_nx = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)              state_nx = IDLE;
        else if (!MOSI)        state_nx = WRITE;
        else if (rd_addr_done) state_nx = READ_DATA;
        else                   state_nx = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // The rx_valid cycle itself is skipped so a tx_valid left high from
  // the previous transfer is never taken as fresh data.
  assign tx_cap = (state == READ_DATA) && frame_done && !tx_sent &&
                  !rx_valid && tx_valid;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt          <= '0;
      shreg        <= '0;
      frame_done   <= 1'b0;
      rd_addr_done <= 1'b0;
      tx_sent      <= 1'b0;
      tx_cnt       <= '0;
      tx_sh        <= '0;
      MISO         <= 1'b0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (SS_n || state == IDLE || state == CHK_CMD) begin
        cnt        <= '0;
        frame_done <= 1'b0;
        tx_sent    <= 1'b0;
        tx_cnt     <= '0;
        tx_sh      <= '0;
        MISO       <= 1'b0;
      end else begin
        if (!frame_done) begin
          if (cnt != NBITS) begin
            shreg <= {shreg[W-2:0], MOSI};
            cnt   <= cnt + 4'd1;
          end else begin
            rx_data    <= shreg;
            rx_valid   <= 1'b1;
            frame_done <= 1'b1;
            if (state == READ_ADD)  rd_addr_done <= 1'b1;
            if (state == READ_DATA) rd_addr_done <= 1'b0;
          end
        end
        if (tx_cap) begin
          MISO    <= tx_data[ADDR_SIZE-1];
          tx_sh   <= {tx_data[ADDR_SIZE-2:0], 1'b0};
          tx_cnt  <= TXLAST;
          tx_sent <= 1'b1;
        end else if (tx_cnt != 4'd0) begin
          MISO   <= tx_sh[ADDR_SIZE-1];
          tx_sh  <= {tx_sh[ADDR_SIZE-2:0], 1'b0};
          tx_cnt <= tx_cnt - 4'd1;
        end else begin
          MISO <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Testbench for spi_slave_if: frame-level reference model with
// randomized payloads, abort points and tx handshakes.
module tb_spi_slave_if;

  logic       clk;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int  pass;
  int  total;
  bit  rd_flag;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .SS_n     (ss_n),
    .MOSI     (mosi),
    .MISO     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle i: inputs driven at the negedge before rising edge i, outputs
  // observed at the negedge after it. in[0] is idle, in[1] the mode bit,
  // in[2..11] the word (MSB first); the pulse shows after edge 12.
  // txm: 0 no tx_valid, 1 stub answers after seeing rx_valid,
  //      2 sticky tx_valid with stale 8'h11 until cycle 14.
  task automatic run_frame(input bit mode, input logic [9:0] w,
                           input int len, input int txm,
                           input logic [7:0] d, input int rst_i);
    int n;
    int endl;
    int cap;
    bit complete;
    bit is_data;
    logic [7:0] capd;
    logic ev;
    logic tv;
    logic [7:0] td;
    n = len + 4;
    endl = (rst_i >= 0 && rst_i < len) ? rst_i : len;
    complete = (endl >= 13);
    is_data = mode && rd_flag;
    cap = -1;
    capd = 8'h00;
    for (int i = 0; i < n; i++) begin
      tv = 1'b0;
      td = 8'($urandom);
      if (txm == 1 && i >= 13) begin
        tv = 1'b1;
        td = d;
      end
      if (txm == 2) begin
        tv = 1'b1;
        td = (i >= 14) ? d : 8'h11;
      end
      ss_n = (i < endl) ? 1'b0 : 1'b1;
      if (i == 1) mosi = mode;
      else if (i >= 2 && i <= 11) mosi = w[11-i];
      else mosi = 1'($urandom);
      tx_valid = tv;
      tx_data = td;
      if (i == rst_i + 1) rst = 1'b1;
      if (i == rst_i) begin
        rst = 1'b0;
        #1;
        total++;
        if (miso !== 1'b0)
          $display("FAIL rst_miso cyc=%0d got=%b exp=0", i, miso);
        else pass++;
      end
      if (cap < 0 && is_data && complete && i >= 14 && i < endl && tv) begin
        cap = i;
        capd = td;
      end
      @(negedge clk);
      ev = 1'b0;
      if (cap >= 0 && i >= cap && i <= cap + 7 && i < endl)
        ev = capd[7-(i-cap)];
      total++;
      if (miso !== ev)
        $display("FAIL miso cyc=%0d got=%b exp=%b", i, miso, ev);
      else pass++;
      total++;
      if (rx_valid !== (complete && i == 12))
        $display("FAIL rx_valid cyc=%0d got=%b exp=%b", i, rx_valid,
                 complete && i == 12);
      else pass++;
      if (complete && i == 12) begin
        total++;
        if (rx_data !== w)
          $display("FAIL rx_data got=%h exp=%h", rx_data, w);
        else pass++;
      end
    end
    if (rst_i >= 0 && rst_i < len) rd_flag = 1'b0;
    else if (complete && mode) rd_flag = ~rd_flag;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (2) @(negedge clk);
    total++;
    if (miso !== 1'b0) $display("FAIL reset_miso got=%b exp=0", miso);
    else pass++;
    total++;
    if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got=%b exp=0", rx_valid);
    else pass++;
    total++;
    if (rx_data !== 10'h000) $display("FAIL reset_rx_data got=%h exp=000", rx_data);
    else pass++;
    rst = 1'b1;
    rd_flag = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write;
    run_frame(1'b0, 10'h0A5, 16, 0, 8'h00, -1);
    run_frame(1'b0, 10'($urandom), 20, 1, 8'($urandom), -1);
  endtask

  task automatic test_read_pair;
    run_frame(1'b1, 10'h230, 16, 0, 8'h00, -1);
    run_frame(1'b1, 10'h300, 26, 1, 8'hC3, -1);
  endtask

  task automatic test_sticky;
    run_frame(1'b1, 10'($urandom), 16, 0, 8'h00, -1);
    run_frame(1'b1, 10'($urandom), 26, 2, 8'h7E, -1);
  endtask

  task automatic test_abort;
    run_frame(1'b0, 10'($urandom), 8, 0, 8'h00, -1);
    run_frame(1'b0, 10'h0A5, 16, 0, 8'h00, -1);
    run_frame(1'b0, 10'($urandom), 11, 0, 8'h00, -1);
    run_frame(1'b1, 10'($urandom), 11, 0, 8'h00, -1);
  endtask

  task automatic test_rst_mid_read;
    if (rd_flag) run_frame(1'b1, 10'($urandom), 16, 0, 8'h00, -1);
    run_frame(1'b1, 10'($urandom), 16, 0, 8'h00, -1);
    run_frame(1'b1, 10'($urandom), 26, 1, 8'hA5, 17);
    run_frame(1'b1, 10'($urandom), 26, 1, 8'hFF, -1);
    run_frame(1'b1, 10'($urandom), 26, 1, 8'h5A, -1);
  endtask

  task automatic test_random;
    int len;
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 2))
        0:       len = $urandom_range(2, 11);
        1:       len = $urandom_range(13, 18);
        default: len = 24 + $urandom_range(0, 4);
      endcase
      run_frame(1'($urandom), 10'($urandom), len, $urandom_range(0, 2),
                8'($urandom), -1);
    end
  endtask

  initial begin
    pass = 0;
    total = 0;
    rd_flag = 1'b0;
    rst = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    test_reset();
    test_write();
    test_read_pair();
    test_sticky();
    test_abort();
    test_rst_mid_read();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
